// File: rtl/dt_walker.sv
// Table-driven decision-tree walker: one node per clock from root 0, valid/ready in and out,
// node table loaded through a config write port that only accepts writes while idle.
module dt_walker #(
  parameter int unsigned N_FEAT    = 8,
  parameter int unsigned CLASS_W   = 2,
  parameter int unsigned N_NODES   = 64,
  parameter int unsigned ADDR_W    = 6,
  parameter int unsigned FIDX_W    = 3,
  parameter int unsigned MAX_DEPTH = 8,
  localparam int unsigned NODE_W   = 1 + FIDX_W + 2 * ADDR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_FEAT-1:0]  in_feat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic               out_err,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [NODE_W-1:0]  cfg_data,
  output logic               cfg_rej
);

  localparam int unsigned DepthW = $clog2(MAX_DEPTH + 1);
  localparam logic [NODE_W-1:0] LeafZero = {1'b1, {(NODE_W - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StWalk, StDone} state_e;

  state_e              state_q, state_d;
  logic [N_FEAT-1:0]   feat_q, feat_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [DepthW-1:0]   depth_q, depth_d;
  logic [CLASS_W-1:0]  class_q, class_d;
  logic                err_q, err_d;
  logic                rej_q, rej_d;
  logic [NODE_W-1:0]   tbl_q [N_NODES];
  logic [NODE_W-1:0]   tbl_d [N_NODES];

  // Current node decode
  logic [NODE_W-1:0] node;
  logic              node_leaf;
  logic [FIDX_W-1:0] node_fidx, fidx_eff;
  logic [ADDR_W-1:0] node_t, node_f, nxt;
  logic              fbit, nxt_bad, depth_last, cfg_ok;

  assign node       = tbl_q[cur_q];
  assign node_leaf  = node[NODE_W-1];
  assign node_fidx  = node[NODE_W-2 -: FIDX_W];
  assign node_t     = node[2*ADDR_W-1 -: ADDR_W];
  assign node_f     = node[ADDR_W-1:0];
  // Out-of-range feature indices fall back to feature bit 0.
  assign fidx_eff   = (32'(node_fidx) < N_FEAT) ? node_fidx : '0;
  assign fbit       = feat_q[fidx_eff];
  assign nxt        = fbit ? node_t : node_f;
  assign nxt_bad    = 32'(nxt) >= N_NODES;
  assign depth_last = (32'(depth_q) + 32'd1) == MAX_DEPTH;

  assign cfg_ok = cfg_we && (state_q == StIdle) && (32'(cfg_addr) < N_NODES);
  assign rej_d  = cfg_we && !cfg_ok;

  always_comb begin
    tbl_d = tbl_q;
    if (cfg_ok) begin
      tbl_d[cfg_addr] = cfg_data;
    end
  end

  always_comb begin
    state_d = state_q;
    feat_d  = feat_q;
    cur_d   = cur_q;
    depth_d = depth_q;
    class_d = class_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          feat_d  = in_feat;
          cur_d   = '0;
          depth_d = '0;
          state_d = StWalk;
        end
      end
      StWalk: begin
        if (node_leaf) begin
          class_d = node_f[CLASS_W-1:0];
          err_d   = 1'b0;
          state_d = StDone;
        end else if (nxt_bad || depth_last) begin
          class_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          cur_d   = nxt;
          depth_d = depth_q + DepthW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      feat_q  <= '0;
      cur_q   <= '0;
      depth_q <= '0;
      class_q <= '0;
      err_q   <= 1'b0;
      rej_q   <= 1'b0;
      for (int i = 0; i < int'(N_NODES); i++) begin
        tbl_q[i] <= LeafZero;
      end
    end else begin
      state_q <= state_d;
      feat_q  <= feat_d;
      cur_q   <= cur_d;
      depth_q <= depth_d;
      class_q <= class_d;
      err_q   <= err_d;
      rej_q   <= rej_d;
      tbl_q   <= tbl_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign out_class = class_q;
  assign out_err   = err_q;
  assign cfg_rej   = rej_q;

endmodule

// File: doc/dt_walker.md
Name: dt_walker

Overview:
- Sequential, table-driven decision-tree classifier; successor to the fixed combinational tree classifiers in the dt flow.
- The tree is held in a runtime-programmable node table. The walker traverses one node per clock from root address 0 and returns a class label.
- Sits between the feature-vector source and the class consumer, with valid/ready on both sides and a config write port for loading the tree.

Parameters:
- N_FEAT, 8, width of input feature vector (one bit per feature)
- CLASS_W, 2, width of class label
- N_NODES, 64, node table depth
- ADDR_W, 6, node address width; must satisfy 2**ADDR_W >= N_NODES
- FIDX_W, 3, feature index width; must satisfy 2**FIDX_W >= N_FEAT
- MAX_DEPTH, 8, maximum number of nodes visited per sample before abort

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  feature vector valid
- in_ready  out  1  walker can accept a sample
- in_feat  in  N_FEAT  feature vector
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_class  out  CLASS_W  class label
- out_err  out  1  traversal aborted (depth limit or bad child address)
- cfg_we  in  1  node table write strobe
- cfg_addr  in  ADDR_W  node address
- cfg_data  in  NODE_W  node word, NODE_W = 1+FIDX_W+2*ADDR_W
- cfg_rej  out  1  one-cycle pulse: write rejected

Behaviour:
- Node word, MSB to LSB: LEAF | FIDX | T_ADDR | F_ADDR.
  - Leaf node: class = F_ADDR[CLASS_W-1:0]; other fields ignored.
  - Internal node: next = in_feat[FIDX] ? T_ADDR : F_ADDR.
  - FIDX >= N_FEAT reads as feature bit 0.
- Reset (async, rst_n low):
  - FSM -> IDLE; in_ready=1; out_valid=0; out_class=0; out_err=0; cfg_rej=0.
  - Every table entry -> leaf, class 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch in_feat, cur=0, depth=0, go to WALK.
  - WALK: in_ready=0. Each cycle, read node[cur] combinationally.
    - Leaf: register class, out_err=0, go to DONE.
    - Internal, next >= N_NODES: out_class=0, out_err=1, go to DONE.
    - Internal, depth+1 == MAX_DEPTH: out_class=0, out_err=1, go to DONE.
    - Otherwise: cur=next, depth+1.
  - DONE: out_valid=1; out_class/out_err held stable while out_ready=0. On out_ready: out_valid=0, return to IDLE.
- Latency: accept on edge E0. A leaf at depth d (root=0) sets out_valid after edge E(d+1). A root leaf gives out_valid one cycle after accept. Worst case is MAX_DEPTH cycles.
- Throughput: one sample in flight. in_ready is low during WALK and DONE. No back-to-back accept in the cycle out_valid drops; accept is possible from the following IDLE cycle.
- Config writes:
  - Accepted only in IDLE; written at the clock edge and visible to a sample accepted at that same edge.
  - cfg_we in WALK/DONE: write dropped; cfg_rej pulses high for exactly one cycle.
  - cfg_addr >= N_NODES: write dropped; cfg_rej pulses.
  - Simultaneous cfg_we and in_valid in IDLE: both take effect; the sample sees the new word.
- Reset mid-walk or in DONE: walk discarded, pending result lost, table reverts to reset contents.
- Tree loops (child pointing at an ancestor) terminate via MAX_DEPTH with out_err=1.

Test Plan:
- Reset then in_feat=0x5A with no programming -> out_valid after E1, out_class=0, out_err=0.
- Program tree:
  - node0 internal FIDX=5, T=1, F=2
  - node1 leaf class 3
  - node2 internal FIDX=0, T=3, F=4
  - node3 leaf class 1
  - node4 leaf class 2
  - Results: 0x20 -> class 3 after E2; 0x01 -> class 1 after E3; 0x00 -> class 2 after E3.
- Depth/address errors:
  - node0 T=F=0 (self loop), any input -> out_err=1, out_class=0, out_valid after E8.
  - node0 F=63 with N_NODES=60 -> out_err=1 after E1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_valid/out_class stable, in_ready=0. out_ready=1 -> next sample accepted the following cycle.
- cfg_we during WALK, and cfg_addr=62 with N_NODES=60 -> cfg_rej one-cycle pulse, table unchanged (rerun sample, same class).
- Assert rst_n low during WALK at depth 2 -> out_valid=0 and in_ready=1 immediately; subsequent sample returns class 0 (table reset).
